// File: rtl/tdc_readout_pkg.sv
// -----------------------------------------------------------------------------
// tdc_readout_pkg
// Shared definitions for the vernier-line TDC readout block: the measurement
// FSM state encoding, default parameter values and the result format.
// No ports (package).
// -----------------------------------------------------------------------------
package tdc_readout_pkg;

    // Measurement FSM states, in the order a sample walks through them.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_STOP = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CONVERT   = 3'd4,
        ST_ACCUM     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Default parameter values.
    localparam int DEF_N_TAPS      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_SETTLE      = 3;

    // Result is unsigned 4.4 fixed point.
    localparam int RESULT_W = 8;
    localparam int FRAC_W   = 4;

    // avg_log2 width: burst length 2^0 .. 2^7.
    localparam int AVG_W = 3;

endpackage

// File: rtl/tdc_sync.sv
// -----------------------------------------------------------------------------
// tdc_sync
// Multi-flop synchronizer for asynchronous inputs, parameterized in width and
// depth. Each bit is synchronized independently.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, clears all stages
//   d      in   [WIDTH] asynchronous input
//   q      out  [WIDTH] synchronized output (STAGES clk of latency)
// -----------------------------------------------------------------------------
module tdc_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/tdc_readout.sv
// -----------------------------------------------------------------------------
// tdc_readout
// Readout controller for a vernier delay-line TDC. On start it runs a burst of
// 2^avg_log2 samples: fire the start edge, wait for the stop edge (or time
// out), let the line settle, popcount the thermometer code and accumulate.
// The burst mean is presented as an unsigned 4.4 tap count.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   burst request pulse (ignored while busy)
//   avg_log2   in   [3] burst length exponent, latched when a burst starts
//   term       in   [N_TAPS] asynchronous thermometer code
//   stop_seen  in   asynchronous stop-arrived level
//   launch     out  one-cycle pulse firing the start edge
//   busy       out  burst in progress
//   valid      out  result/ovf/unf hold a completed burst
//   result     out  [8] mean tap count, 4.4 fixed point, saturating
//   ovf        out  some sample was all-ones or timed out
//   unf        out  some sample was all-zeros
//   state_dbg  out  current FSM state, for observation only
//
// Handshake: start is accepted only on a cycle where busy=0 (IDLE or DONE);
// acceptance drops valid and raises busy on the next edge. busy stays high
// until the edge that raises valid; valid then holds, with result/ovf/unf
// stable, until the next accepted start.
// -----------------------------------------------------------------------------
module tdc_readout
    import tdc_readout_pkg::*;
#(
    parameter int N_TAPS      = DEF_N_TAPS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SETTLE      = DEF_SETTLE   // must be >= 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AVG_W-1:0]    avg_log2,
    input  logic [N_TAPS-1:0]   term,
    input  logic                stop_seen,
    output logic                launch,
    output logic                busy,
    output logic                valid,
    output logic [RESULT_W-1:0] result,
    output logic                ovf,
    output logic                unf,
    output state_t              state_dbg
);

    localparam int PC_W    = $clog2(N_TAPS + 1);
    localparam int ACC_W   = PC_W + 7;             // holds N_TAPS * 128
    localparam int SCL_W   = ACC_W + FRAC_W;
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [N_TAPS-1:0]   term_s;
    logic                stop_s;
    logic [1:0]          rst_pipe;
    logic                rst_ready;
    state_t              state;
    logic [AVG_W-1:0]    avg_q;
    logic [ACC_W-1:0]    acc;
    logic [7:0]          nsamp;
    logic [CNT_W-1:0]    cnt;
    logic [PC_W-1:0]     sample;
    logic [PC_W-1:0]     pc;
    logic [ACC_W-1:0]    acc_next;
    logic [SCL_W-1:0]    scaled;
    logic [RESULT_W-1:0] res_sat;
    logic                last_sample;

    tdc_sync #(.WIDTH(N_TAPS), .STAGES(SYNC_STAGES)) u_sync_term (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (term),
        .q     (term_s)
    );

    tdc_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stop_seen),
        .q     (stop_s)
    );

    // Reset release is retimed so the FSM never acts on the first edges
    // after deassertion; start is gated until rst_ready rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_ready = rst_pipe[1];

    // Counting ones rather than finding the edge makes bubbles harmless.
    always_comb begin
        pc = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            pc = pc + PC_W'(term_s[i]);
        end
    end

    assign acc_next    = acc + ACC_W'(sample);
    assign scaled      = {acc_next, {FRAC_W{1'b0}}} >> avg_q;
    assign res_sat     = (scaled > SCL_W'(2**RESULT_W - 1)) ? {RESULT_W{1'b1}}
                                                            : scaled[RESULT_W-1:0];
    assign last_sample = (nsamp + 8'd1) == (8'd1 << avg_q);
    assign state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            launch <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            avg_q  <= '0;
            acc    <= '0;
            nsamp  <= '0;
            cnt    <= '0;
            sample <= '0;
        end else begin
            launch <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && rst_ready) begin
                        avg_q  <= avg_log2;
                        acc    <= '0;
                        nsamp  <= '0;
                        ovf    <= 1'b0;
                        unf    <= 1'b0;
                        valid  <= 1'b0;
                        busy   <= 1'b1;
                        launch <= 1'b1;
                        state  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT_STOP;
                end
                ST_WAIT_STOP: begin
                    // A stop arriving on the timeout cycle still counts.
                    if (stop_s) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        sample <= PC_W'(N_TAPS);
                        ovf    <= 1'b1;
                        state  <= ST_ACCUM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE - 1)) begin
                        state <= ST_CONVERT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CONVERT: begin
                    sample <= pc;
                    if (&term_s) ovf <= 1'b1;
                    if (~|term_s) unf <= 1'b1;
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc   <= acc_next;
                    nsamp <= nsamp + 8'd1;
                    if (last_sample) begin
                        result <= res_sat;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        launch <= 1'b1;
                        state  <= ST_LAUNCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_readout.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout
// Self-checking bench for tdc_readout. A responder plays the delay line: on
// each launch it presents the next thermometer code and pulses stop_seen.
// Expected burst results come from a small model and go through exp_q.
// -----------------------------------------------------------------------------
module tb_tdc_readout;
    import tdc_readout_pkg::*;

    localparam int N_TAPS  = 8;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 255;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [7:0]  term = 8'h00;
    logic        stop_seen = 1'b0;
    logic        launch, busy, valid, ovf, unf;
    logic [7:0]  result;
    state_t      state_dbg;

    always #5 clk = ~clk;

    tdc_readout #(
        .N_TAPS      (N_TAPS),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT),
        .SETTLE      (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .avg_log2  (avg_log2),
        .term      (term),
        .stop_seen (stop_seen),
        .launch    (launch),
        .busy      (busy),
        .valid     (valid),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         launch_cnt = 0;
    bit         auto_stop = 1'b0;
    int         stop_delay = 2;
    logic [7:0] term_seq[$];
    logic [9:0] exp_q[$];          // {result, ovf, unf}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (launch === 1'b1) launch_cnt++;
    end

    // Delay-line responder.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_stop && launch === 1'b1) begin
                if (term_seq.size() > 0) term = term_seq.pop_front();
                repeat (stop_delay) @(negedge clk);
                stop_seen = 1'b1;
                repeat (2) @(negedge clk);
                stop_seen = 1'b0;
            end
        end
    end

    // Expected {result, ovf, unf} for a burst, from the pending term codes.
    function automatic logic [9:0] model(input int avg, input bit tmo);
        int         sum;
        int         r;
        logic       o;
        logic       u;
        logic [7:0] v;
        sum = 0; o = 1'b0; u = 1'b0;
        for (int i = 0; i < (1 << avg); i++) begin
            if (i < term_seq.size()) v = term_seq[i];
            else if (term_seq.size() > 0) v = term_seq[term_seq.size()-1];
            else v = term;
            if (tmo) begin
                sum += N_TAPS;
                o = 1'b1;
            end else begin
                sum += $countones(v);
                if (v == 8'hFF) o = 1'b1;
                if (v == 8'h00) u = 1'b1;
            end
        end
        r = (sum * 16) >> avg;
        if (r > 255) r = 255;
        return {r[7:0], o, u};
    endfunction

    // ---------------- driver ----------------
    task automatic run_burst(input string name, input int avg, input bit tmo,
                             input int exp_lat, input int poke_at);
        logic [9:0] e;
        int         k;
        e = model(avg, tmo);
        exp_q.push_back(e);
        launch_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        avg_log2 = avg[2:0];
        @(negedge clk);
        start = 1'b0;
        avg_log2 = 3'($urandom_range(0, 7));   // must not matter after latch
        k = 1;
        check({name, " busy"}, busy, 1'b1);
        while (valid !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
            start = (k == poke_at);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (valid !== 1'b1) begin
            check({name, " valid_wait"}, 32'd0, 32'd1);
        end else begin
            check({name, " result"}, result, e[9:2]);
            check({name, " ovf"}, ovf, e[1]);
            check({name, " unf"}, unf, e[0]);
            check({name, " launches"}, launch_cnt, 1 << avg);
            check({name, " busy_done"}, busy, 1'b0);
            if (exp_lat > 0) check({name, " latency"}, k, exp_lat);
        end
        term_seq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " launch"}, launch, 1'b0);
        check({name, " busy"}, busy, 1'b0);
        check({name, " valid"}, valid, 1'b0);
        check({name, " ovf"}, ovf, 1'b0);
        check({name, " unf"}, unf, 1'b0);
        check({name, " result"}, result, 8'h00);
        check({name, " state"}, state_dbg, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // start on the very first edge after release must be ignored
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_sync start_ignored", busy, 1'b0);
        repeat (3) @(negedge clk);

        // stop already high before launch: minimum latency
        auto_stop = 1'b0;
        stop_seen = 1'b1;
        term = 8'h0F;
        repeat (3) @(negedge clk);
        run_burst("lat_min", 0, 1'b0, SETTLE + 5, 0);
        stop_seen = 1'b0;
        repeat (4) @(negedge clk);

        auto_stop = 1'b1;
        stop_delay = 2;
        term_seq = '{8'h0F};
        run_burst("single_0f", 0, 1'b0, 0, 0);

        term_seq = '{8'h0F, 8'h1F, 8'h07, 8'h3F};
        run_burst("avg4_seq", 2, 1'b0, 0, 0);

        auto_stop = 1'b0;
        repeat (4) @(negedge clk);
        run_burst("timeout", 0, 1'b1, TIMEOUT + 4, 0);

        auto_stop = 1'b1;
        term_seq = '{8'b0101_1111};
        run_burst("bubble", 0, 1'b0, 0, 0);
        term_seq = '{8'h00};
        run_burst("zeros", 0, 1'b0, 0, 0);

        for (int i = 0; i < 4; i++) term_seq.push_back(8'($urandom_range(0, 255)));
        run_burst("start_ignored", 2, 1'b0, 0, 10);

        for (int n = 0; n < 4; n++) begin
            int a;
            a = $urandom_range(0, 3);
            stop_delay = $urandom_range(0, 4);
            for (int i = 0; i < 8; i++) term_seq.push_back(8'($urandom_range(0, 255)));
            run_burst($sformatf("rand%0d", n), a, 1'b0, 0, 0);
        end
        stop_delay = 2;

        term_seq = '{8'hFF};
        run_burst("avg128_ff", 7, 1'b0, 0, 0);

        // reset in the middle of a burst
        term = 8'h0F;
        @(negedge clk);
        start = 1'b1;
        avg_log2 = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("midrst no_partial", seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tdc_readout.md
TDC_READOUT -- requirements
Module: tdc_readout

Interface
REQ-001 Parameter N_TAPS, default 8: vernier delay line thermometer width.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flops per asynchronous input synchronizer.
REQ-003 Parameter TIMEOUT, default 255: clk cycles waited for a stop event per sample.
REQ-004 Parameter SETTLE, default 3: clk cycles between stop detection and thermometer sampling.
REQ-005 clk  input  1  single system clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  synchronous request pulse; begins a measurement burst.
REQ-008 avg_log2  input  3  burst length = 2^avg_log2 samples (1..128); sampled at burst start.
REQ-009 term  input  N_TAPS  asynchronous thermometer code from the vernier delay line.
REQ-010 stop_seen  input  1  asynchronous level, high once the stop edge has propagated.
REQ-011 launch  output  1  one-cycle pulse that fires the start edge into the diff generator.
REQ-012 busy  output  1  high from burst acceptance until valid rises.
REQ-013 valid  output  1  high while result holds a completed burst.
REQ-014 result  output  8  mean tap count, unsigned 4.4 fixed point.
REQ-015 ovf  output  1  sticky per burst: any sample all-ones or timed out.
REQ-016 unf  output  1  sticky per burst: any sample all-zeros.

Function
REQ-017 term and stop_seen each pass through a SYNC_STAGES flop synchronizer before any use.
REQ-018 FSM states: IDLE, LAUNCH, WAIT_STOP, SETTLE, CONVERT, ACCUM, DONE.
REQ-019 IDLE or DONE, start=1: latch avg_log2, clear accumulator/sample counter/ovf/unf, drop valid, raise busy, go LAUNCH.
REQ-020 start while busy=1 is ignored, with no effect on the burst.
REQ-021 LAUNCH: launch=1 for exactly one cycle, timeout counter cleared, go WAIT_STOP.
REQ-022 WAIT_STOP: synced stop_seen=1 -> SETTLE; counter reaching TIMEOUT -> ACCUM with sample value N_TAPS and ovf set.
REQ-023 SETTLE: hold SETTLE cycles, then CONVERT.
REQ-024 CONVERT: sample value = popcount of synced term (bubble-tolerant, 0..N_TAPS); all-ones sets ovf, all-zeros sets unf; go ACCUM.
REQ-025 ACCUM: accumulator += sample value, sample counter +1; counter equal to 2^avg_log2 -> DONE, else LAUNCH.
REQ-026 Accumulator width is clog2(N_TAPS+1)+7 bits (11 for N_TAPS=8) and never wraps.
REQ-027 result = (accumulator << 4) >> avg_log2, truncated, saturating at 8'hFF; registered on entry to DONE.
REQ-028 DONE: valid=1, busy=0; result/ovf/unf held until the next accepted start.
REQ-029 Latency, one sample, avg_log2=0, stop in first WAIT_STOP cycle: valid rises SETTLE+5 cycles after start.
REQ-030 stop_seen already high in LAUNCH is treated as a valid stop on the first WAIT_STOP cycle.

Reset
REQ-031 rst_n low: FSM=IDLE; launch, busy, valid, ovf, unf = 0; result = 8'h00; accumulator, counters and synchronizers = 0.
REQ-032 Reset mid-burst aborts it at once; no partial result is ever presented.
REQ-033 Reset deassertion is synchronized internally; the first start is accepted no earlier than the second clk edge after release.

Structure
REQ-034 A shared package holds the FSM state enum, default parameter constants, and the 4.4 result format width.
REQ-035 Sub-module tdc_sync (parameterized-width multi-flop synchronizer) is instantiated for term and for stop_seen.
REQ-036 The popcount is combinational logic inside tdc_readout; it is not a separate module.

Verification
REQ-037 avg_log2=0, term=8'h0F, stop after 2 cycles -> one launch pulse, result=8'h40, ovf=0, unf=0.
REQ-038 avg_log2=2, term sequence 0F,1F,07,3F -> four launch pulses, result=8'h48.
REQ-039 stop_seen never asserted, avg_log2=0 -> valid after TIMEOUT+4 cycles, result=8'h80, ovf=1.
REQ-040 Bubble code term=8'b0101_1111 -> sample value 6, result=8'h60; term=8'h00 -> result=8'h00, unf=1.
REQ-041 start pulsed again during burst -> ignored, launch count unchanged; rst_n low mid-burst -> all outputs return to reset values the same cycle.
REQ-042 avg_log2=7, term=8'hFF every sample -> 128 launches, accumulator=1024 without wrap, result=8'h80, ovf=1.
